pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter WORD_LENGTH, default 20, meaning digit periods per beat (word time); legal range 2..64.
REQ-002 Parameter INSTR_BITS, default 2, meaning width of the phase bus; one instruction cycle has 2**INSTR_BITS beats.
REQ-003 Port clk, input, 1, meaning single system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-005 Port run, input, 1, meaning level request for continuous execution.
REQ-006 Port step, input, 1, meaning single-step key; only its rising edge is used.
REQ-007 Port stop, input, 1, meaning stop-function request from the decoded instruction.
REQ-008 Port ps, output, INSTR_BITS, meaning current beat index, driving the test unit's phase bus.
REQ-009 Port digit, output, $clog2(WORD_LENGTH), meaning digit position within the current beat.
REQ-010 Port action_trigger, output, 1, meaning one-clk pulse that starts the action beat.
REQ-011 Port para_s1, output, 1, meaning high for the whole of beat 0 (Scan1).
REQ-012 Port running, output, 1, meaning the sequencer is in RUN, STEP or HALTING.

Function
REQ-013 The block SHALL be the initiator feeding the test unit: all outputs SHALL be registered, with no combinational path from input to output.
REQ-014 The FSM SHALL have four states: IDLE, RUN, STEP and HALTING.
REQ-015 In IDLE the outputs SHALL be: ps=0, digit=0, action_trigger=0, para_s1=0, running=0.
REQ-016 Outside IDLE, digit SHALL increment every clk and wrap from WORD_LENGTH-1 to 0.
REQ-017 At that wrap, ps SHALL increment modulo 2**INSTR_BITS.
REQ-018 The last beat (ps all-ones) ending at digit WORD_LENGTH-1 SHALL mark the instruction boundary.
REQ-019 action_trigger SHALL be 1 for exactly the clk where ps is all-ones and digit is 0, and 0 otherwise.
REQ-020 para_s1 SHALL equal (ps==0) whenever the state is not IDLE.
REQ-021 IDLE SHALL go to RUN when run=1 is sampled; the first active cycle (ps=0, digit=0, para_s1=1) SHALL appear on the next clk (latency 1).
REQ-022 IDLE SHALL go to STEP on a rising edge of step while run=0; latency SHALL be 1, as for run.
REQ-023 If run=1 and a step edge coincide in IDLE, run SHALL win.
REQ-024 RUN SHALL go to HALTING when stop=1 or run=0 is sampled.
REQ-025 HALTING SHALL finish the current instruction and enter IDLE on the clk after the boundary.
REQ-026 If stop is sampled exactly at the boundary cycle, RUN SHALL go directly to IDLE without starting a new instruction.
REQ-027 STEP SHALL execute exactly one instruction cycle (WORD_LENGTH * 2**INSTR_BITS clks) and then enter IDLE.
REQ-028 Step edges in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 In STEP, the stop and run inputs SHALL be ignored.
REQ-030 Re-asserting run while HALTING SHALL NOT cancel the halt; the block SHALL restart from IDLE.

Reset
REQ-031 Asserting rst_n=0 SHALL force the IDLE outputs of REQ-015 immediately, at any point including mid-beat.
REQ-032 Reset SHALL clear the step edge-detect register so that a held step key is not seen as an edge after release of reset.
REQ-033 After reset, no action_trigger SHALL occur until a new run or step is accepted.

Configuration
REQ-034 With macro PULSE_SEQ_SINGLE_STEP_EN defined, STEP SHALL behave per REQ-022 and REQ-027 to REQ-029.
REQ-035 Without PULSE_SEQ_SINGLE_STEP_EN, the step port SHALL be present but ignored, the STEP state and edge detector SHALL be omitted, and IDLE SHALL leave only via run.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, default WORD_LENGTH=20, default INSTR_BITS=2, and the beat index constants SCAN1=0 and ACTION=2**INSTR_BITS-1.
REQ-037 One sub-module, beat_counter, SHALL hold the digit/ps counter pair with enable, synchronous clear and a boundary flag; the FSM SHALL live in pulse_sequencer.

Verification
REQ-038 Run for 3 instructions: hold run=1 from reset release -> ps steps 0,1,2,3 every 20 clks, para_s1 high 20 clks per 80, action_trigger pulses at clks 61, 141 and 221 after acceptance.
REQ-039 Stop mid-instruction: stop=1 at ps=1, digit=7 -> sequence continues to ps=3, digit=19, then IDLE, with running=0 on the next clk.
REQ-040 Single step: step rising edge in IDLE -> exactly 80 active clks and one action_trigger, then IDLE; a second step edge at clk 40 -> no effect.
REQ-041 Simultaneous run=1 and step edge in IDLE -> RUN; after run=0 -> halt at the boundary, with no extra step cycle.
REQ-042 Reset mid-beat: rst_n=0 at ps=2, digit=11 -> outputs zero asynchronously; after release with run=0 -> remains IDLE.
REQ-043 Build without PULSE_SEQ_SINGLE_STEP_EN: step pulses in IDLE -> running stays 0 for 200 clks.

Source files
------------

// File: rtl/pulse_sequencer_pkg.sv
// Shared state encoding, default geometry and beat constants for pulse_sequencer.
// ST_STEP exists only when PULSE_SEQ_SINGLE_STEP_EN is defined.
package pulse_sequencer_pkg;

  localparam int DEF_WORD_LENGTH = 20;
  localparam int DEF_INSTR_BITS  = 2;
  localparam int SCAN1           = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
`ifdef PULSE_SEQ_SINGLE_STEP_EN
    ST_STEP    = 2'd2,
`endif
    ST_HALTING = 2'd3
  } seq_state_e;

  // ACTION beat index: the last beat of an instruction (ps all-ones).
  function automatic int action_beat(input int instr_bits);
    return (1 << instr_bits) - 1;
  endfunction

endpackage

// File: rtl/pulse_sequencer_beat_counter.sv
// beat_counter: digit position within a beat and beat index within an instruction.
// Next-state values are exported so the owner can register decoded outputs alongside.
module beat_counter
  import pulse_sequencer_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int INSTR_BITS  = DEF_INSTR_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           clr_i,
  output logic [$clog2(WORD_LENGTH)-1:0] digit_o,
  output logic [$clog2(WORD_LENGTH)-1:0] digit_nxt_o,
  output logic [INSTR_BITS-1:0]          ps_o,
  output logic [INSTR_BITS-1:0]          ps_nxt_o,
  output logic                           boundary_o
);

  localparam int DW = $clog2(WORD_LENGTH);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(WORD_LENGTH - 1);

  logic [DW-1:0]         digit_q, digit_d;
  logic [INSTR_BITS-1:0] ps_q, ps_d;

  always_comb begin
    digit_d = digit_q;
    ps_d    = ps_q;
    if (clr_i) begin
      digit_d = '0;
      ps_d    = '0;
    end else if (en_i) begin
      if (digit_q == DIGIT_LAST) begin
        digit_d = '0;
        ps_d    = ps_q + 1'b1;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      ps_q    <= '0;
    end else begin
      digit_q <= digit_d;
      ps_q    <= ps_d;
    end
  end

  assign digit_o     = digit_q;
  assign ps_o        = ps_q;
  assign digit_nxt_o = digit_d;
  assign ps_nxt_o    = ps_d;
  assign boundary_o  = (ps_q == '1) && (digit_q == DIGIT_LAST);

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: beat/digit timing initiator for the test unit; every output is a flop.
// Single-step mode is built only with PULSE_SEQ_SINGLE_STEP_EN defined.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int INSTR_BITS  = DEF_INSTR_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic                           step,
  input  logic                           stop,
  output logic [INSTR_BITS-1:0]          ps,
  output logic [$clog2(WORD_LENGTH)-1:0] digit,
  output logic                           action_trigger,
  output logic                           para_s1,
  output logic                           running
);

  // state   | meaning
  // IDLE    | outputs at zero, waiting for run (or a step press)
  // RUN     | free-running instruction cycles until stop or run drop
  // STEP    | exactly one instruction cycle, run/stop ignored
  // HALTING | finishing the current instruction, then IDLE

  localparam int DW = $clog2(WORD_LENGTH);
  localparam logic [INSTR_BITS-1:0] PS_SCAN1  = INSTR_BITS'(SCAN1);
  localparam logic [INSTR_BITS-1:0] PS_ACTION = INSTR_BITS'(action_beat(INSTR_BITS));

  seq_state_e            state_q, state_d;
  logic                  running_q, running_d;
  logic                  para_s1_q, para_s1_d;
  logic                  action_q, action_d;
  logic                  cnt_en, cnt_clr, boundary;
  logic [DW-1:0]         digit_cur, digit_nxt;
  logic [INSTR_BITS-1:0] ps_cur, ps_nxt;

`ifdef PULSE_SEQ_SINGLE_STEP_EN
  logic step_q, step_edge;

  // Resets to "pressed" so a key held through reset is not taken as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b1;
    else        step_q <= step;
  end

  assign step_edge = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_RUN;
`ifdef PULSE_SEQ_SINGLE_STEP_EN
        else if (step_edge) state_d = ST_STEP;
`endif
      end
      // A halt request seen on the boundary cycle must not start another instruction.
      ST_RUN: begin
        if (stop || !run) state_d = boundary ? ST_IDLE : ST_HALTING;
      end
      ST_HALTING: begin
        if (boundary) state_d = ST_IDLE;
      end
`ifdef PULSE_SEQ_SINGLE_STEP_EN
      ST_STEP: begin
        if (boundary) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_en  = (state_q != ST_IDLE);
  assign cnt_clr = (state_d == ST_IDLE);

  beat_counter #(
    .WORD_LENGTH (WORD_LENGTH),
    .INSTR_BITS  (INSTR_BITS)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (cnt_en),
    .clr_i       (cnt_clr),
    .digit_o     (digit_cur),
    .digit_nxt_o (digit_nxt),
    .ps_o        (ps_cur),
    .ps_nxt_o    (ps_nxt),
    .boundary_o  (boundary)
  );

  assign running_d = (state_d != ST_IDLE);
  assign para_s1_d = running_d && (ps_nxt == PS_SCAN1);
  assign action_d  = running_d && (ps_nxt == PS_ACTION) && (digit_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      para_s1_q <= 1'b0;
      action_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      para_s1_q <= para_s1_d;
      action_q  <= action_d;
    end
  end

  assign ps             = ps_cur;
  assign digit          = digit_cur;
  assign running        = running_q;
  assign para_s1        = para_s1_q;
  assign action_trigger = action_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: stimulus queues the expected active-cycle stream,
// a negedge monitor pops and compares whenever running is high and checks zeros otherwise.
module tb_pulse_sequencer;

  localparam int WL    = 20;
  localparam int IB    = 2;
  localparam int BEATS = 1 << IB;
  localparam int IC    = WL * BEATS;

  typedef struct {
    int ps;
    int digit;
    bit para;
    bit act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  run = 1'b0;
  logic                  step = 1'b0;
  logic                  stop = 1'b0;
  logic [IB-1:0]         ps;
  logic [$clog2(WL)-1:0] digit;
  logic                  action_trigger;
  logic                  para_s1;
  logic                  running;

  pulse_sequencer #(
    .WORD_LENGTH (WL),
    .INSTR_BITS  (IB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .step           (step),
    .stop           (stop),
    .ps             (ps),
    .digit          (digit),
    .action_trigger (action_trigger),
    .para_s1        (para_s1),
    .running        (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Reference: the n-th active cycle of a session is beat n/WL (mod BEATS), digit n%WL.
  task automatic push_cycles(input int count);
    exp_t e;
    for (int n = 0; n < count; n++) begin
      e.ps    = (n / WL) % BEATS;
      e.digit = n % WL;
      e.para  = (e.ps == 0);
      e.act   = (e.ps == BEATS - 1) && (e.digit == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected active cycles never seen, required 0", exp_q.size());
      exp_q.delete();
    end
    check("end_idle_running", 32'(running), 0);
  endtask

  // Halt request (stop or run drop) sampled in active cycle n_req finishes that instruction.
  // step_mode: 0 none, 1 random step noise while running, 2 step pressed together with run.
  task automatic do_run(input int n_req, input bit use_stop, input int step_mode);
    push_cycles((n_req / IC + 1) * IC);
    @(posedge clk); #1;
    run = 1'b1;
    if (step_mode == 2) step = 1'b1;
    for (int c = 0; c <= n_req; c++) begin
      @(posedge clk); #1;
      if (step_mode == 1 && c < n_req) step = 1'($urandom_range(0, 1));
    end
    step = 1'b0;
    if (use_stop) stop = 1'b1;
    else run = 1'b0;
    @(posedge clk); #1;
    stop = 1'b0;
    run  = 1'b0;
    drain();
  endtask

  // run held throughout; a one-cycle stop halts, then IDLE sees run and restarts.
  task automatic do_restart(input int n_req, input int m2);
    int l1;
    l1 = (n_req / IC + 1) * IC - 1;
    push_cycles(l1 + 1);
    push_cycles((m2 / IC + 1) * IC);
    @(posedge clk); #1;
    run = 1'b1;
    for (int c = 0; c <= n_req; c++) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat ((3 + l1 + m2) - (2 + n_req)) @(posedge clk);
    #1;
    run = 1'b0;
    drain();
  endtask

`ifdef PULSE_SEQ_SINGLE_STEP_EN
  task automatic do_step();
    push_cycles(IC);
    @(posedge clk); #1;
    step = 1'b1;
    for (int c = 0; c < IC; c++) begin
      @(posedge clk); #1;
      if (c == 5)  step = 1'b0;
      if (c == 39) step = 1'b1;
      if (c == 50) step = 1'b0;
      run  = (c >= 10 && c < 15);
      stop = (c >= 20 && c < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    run  = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    drain();
  endtask
`else
  task automatic do_idle_step();
    int active_seen;
    active_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (running) active_seen++;
      step = 1'($urandom_range(0, 1));
    end
    step = 1'b0;
    check("idle_step_running_cycles", 32'(active_seen), 0);
    drain();
  endtask
`endif

  // Reset lands mid-beat at ps=2, digit=11, with step held through its release.
  task automatic do_reset_mid_beat();
    push_cycles(2 * WL + 12);
    @(posedge clk); #1;
    run = 1'b1;
    for (int c = 0; c <= 2 * WL + 11; c++) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b1;
    #1;
    check("async_reset_outputs", 32'({running, para_s1, action_trigger, ps, digit}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    step = 1'b0;
    drain();
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      checks++;
      if (running) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_active: running=1 ps=%0d digit=%0d, required running=0", ps, digit);
        end else begin
          e = exp_q.pop_front();
          if (int'(ps) != e.ps || int'(digit) != e.digit ||
              para_s1 != e.para || action_trigger != e.act) begin
            errors++;
            $display("FAIL active_cycle: got ps=%0d digit=%0d para_s1=%0d action=%0d, required ps=%0d digit=%0d para_s1=%0d action=%0d",
                     ps, digit, para_s1, action_trigger, e.ps, e.digit, e.para, e.act);
          end
        end
      end else if ({ps, digit, para_s1, action_trigger} != '0) begin
        errors++;
        $display("FAIL idle_outputs: got ps=%0d digit=%0d para_s1=%0d action=%0d, required all 0",
                 ps, digit, para_s1, action_trigger);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int kind;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_state_outputs", 32'({running, para_s1, action_trigger, ps, digit}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_run(3 * IC - 1, 1'b0, 0);
    do_run(1 * WL + 7, 1'b1, 0);
    do_run(IC - 1, 1'b1, 0);
    do_run(IC + 33, 1'b0, 2);
`ifdef PULSE_SEQ_SINGLE_STEP_EN
    do_step();
`else
    do_idle_step();
`endif
    do_restart(45, 100);
    do_reset_mid_beat();

    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        do_run($urandom_range(0, 4 * IC - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 1));
      end else if (kind == 1) begin
        do_restart($urandom_range(0, 2 * IC - 1), $urandom_range(0, 2 * IC - 1));
      end else begin
`ifdef PULSE_SEQ_SINGLE_STEP_EN
        do_step();
`else
        do_run($urandom_range(0, 2 * IC - 1), 1'($urandom_range(0, 1)), 2);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
